nonce_report_tx: RTL and testbench

- Downstream consumer of the universal result combiner in the mining datapath.
- Arms on a host start pulse, counts search cycles and captures the first winning nonce (rising edge of the combined finished flag).
- On a find or a timeout, emits a fixed 10-byte report frame over an 8-bit valid/ready stream to the host-side UART/bridge.
- Holds the result until the next start.

---
 rtl/nonce_report_tx.sv | 86 ++++++++
 tb/tb_nonce_report_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nonce_report_tx.sv
// nonce_report_tx: arms on start, captures the first winning nonce or times out, then streams a 10-byte report.
module nonce_report_tx #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        finished_universal,
  input  logic [31:0] nonce_out_universal,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] nonce_latched
);
  typedef enum logic [2:0] {IDLE, ARMED, LOAD, SEND, DONE} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fin_q;
  logic [31:0]      cyc_q;
  logic [71:0]      frame_q;
  logic [3:0]       idx_q;
  logic             find, tmo;
  assign find = finished_universal & ~fin_q;
  assign tmo  = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  // fin_q resets high so a flag already asserted out of reset is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      fin_q         <= 1'b1;
      cyc_q         <= '0;
      frame_q       <= '0;
      idx_q         <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      nonce_latched <= '0;
    end else begin
      fin_q <= finished_universal;
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= ARMED;
          cnt_q   <= '0;
          busy    <= 1'b1;
          done    <= 1'b0;
          found   <= 1'b0;
        end
        ARMED: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (find || tmo) begin
            state_q       <= LOAD;
            found         <= find;
            nonce_latched <= find ? nonce_out_universal : '0;
            cyc_q         <= find ? 32'(cnt_q) : 32'(TIMEOUT_CYCLES);
          end
        end
        LOAD: begin
          frame_q  <= {found ? 8'h01 : 8'h02, nonce_latched, cyc_q};
          idx_q    <= '0;
          tx_data  <= 8'hA5;
          tx_valid <= 1'b1;
          state_q  <= SEND;
        end
        SEND: if (tx_ready) begin
          if (idx_q == 4'd9) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= DONE;
          end else begin
            tx_data <= frame_q[71:64];
            frame_q <= {frame_q[63:0], 8'h00};
            idx_q   <= idx_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_report_tx.sv
// tb_nonce_report_tx: randomized searches against a frame-level reference model with a queue scoreboard.
module tb_nonce_report_tx;
  localparam int CNT_W = 16;
  localparam int T     = 20;
  logic        clk = 0, reset = 1, start = 0, finished_universal = 1, tx_ready = 1;
  logic [31:0] nonce_out_universal = 0;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done, found;
  logic [31:0] nonce_latched;
  logic [7:0]  exp_q[$];
  int          total = 0, bad = 0, hs_cnt = 0, bp_mode = 0, ph = 0;
  logic        pend_valid = 0;
  logic [7:0]  pend_byte = 0;

  nonce_report_tx #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .start(start), .finished_universal(finished_universal),
    .nonce_out_universal(nonce_out_universal), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .found(found), .nonce_latched(nonce_latched));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    ph++;
    tx_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? (ph % 3 == 0) : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (reset || !tx_valid) pend_valid = 0;
    else begin
      if (pend_valid) chk("hold", {24'h0, tx_data}, {24'h0, pend_byte});
      if (tx_ready) begin
        hs_cnt++;
        pend_valid = 0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte got=%h expected=none", tx_data);
        end else chk("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end else begin
        pend_valid = 1;
        pend_byte  = tx_data;
      end
    end
  end

  task automatic push_frame(input bit f, input logic [31:0] n, input logic [31:0] c);
    exp_q.push_back(8'hA5);
    exp_q.push_back(f ? 8'h01 : 8'h02);
    for (int i = 3; i >= 0; i--) exp_q.push_back(n[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(c[8*i +: 8]);
  endtask

  task automatic arm(input bit fin_init);
    start = 1; finished_universal = fin_init;
    @(posedge clk); #1;
    start = 0;
  endtask

  // ARMED cycle j sees finished high for j<h, low until k, and a fresh edge at k (if k<T)
  task automatic search(input int h, input int k, input logic [31:0] n);
    bit f;
    f = k < T;
    hs_cnt = 0;
    push_frame(f, f ? n : 32'h0, f ? 32'(k) : 32'(T));
    for (int j = 0; j < (f ? k : T); j++) begin
      finished_universal = j < h;
      nonce_out_universal = $urandom;
      @(posedge clk); #1;
    end
    if (f) begin
      finished_universal = 1; nonce_out_universal = n;
      @(posedge clk); #1;
      nonce_out_universal = $urandom;
    end
  endtask

  task automatic finish_frame(input bit f, input logic [31:0] n);
    for (int i = 0; i < 300 && !done; i++) begin @(posedge clk); #1; end
    chk("done", {31'h0, done}, 1);
    chk("found", {31'h0, found}, {31'h0, f});
    chk("nonce_latched", nonce_latched, f ? n : 32'h0);
    chk("busy_done", {31'h0, busy}, 0);
    chk("valid_done", {31'h0, tx_valid}, 0);
    chk("handshakes", hs_cnt, 10);
    chk("queue_left", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    logic [31:0] n;
    repeat (3) @(posedge clk); #1;
    reset = 0;
    chk("rst_valid", {31'h0, tx_valid}, 0);
    chk("rst_data", {24'h0, tx_data}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_found", {31'h0, found}, 0);
    chk("rst_nonce", nonce_latched, 0);
    // level held high out of reset is not a find; edge on ARMED cycle 5
    arm(1);
    chk("armed_busy", {31'h0, busy}, 1);
    search(3, 5, 32'h1234ABCD);
    chk("load_novalid", {31'h0, tx_valid}, 0);
    chk("load_busy", {31'h0, busy}, 1);
    @(posedge clk); #1;
    chk("lat_valid", {31'h0, tx_valid}, 1);
    chk("lat_hdr", {24'h0, tx_data}, 32'hA5);
    finish_frame(1, 32'h1234ABCD);
    // timeout, re-armed from DONE
    arm(0);
    chk("rearm_done", {31'h0, done}, 0);
    chk("rearm_busy", {31'h0, busy}, 1);
    chk("rearm_found", {31'h0, found}, 0);
    search(0, 30, 0);
    finish_frame(0, 0);
    // find coinciding with timeout, under 1,0,0 backpressure
    bp_mode = 1;
    arm(0);
    search(0, T - 1, 32'hCAFEF00D);
    finish_frame(1, 32'hCAFEF00D);
    bp_mode = 0;
    // reset after 4 accepted bytes
    arm(0);
    search(0, 3, 32'h0BADBEEF);
    for (int i = 0; i < 100 && hs_cnt < 4; i++) begin @(posedge clk); #1; end
    chk("hs4_reached", {31'h0, hs_cnt >= 4}, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("mid_valid", {31'h0, tx_valid}, 0);
    chk("mid_data", {24'h0, tx_data}, 0);
    chk("mid_busy", {31'h0, busy}, 0);
    chk("mid_done", {31'h0, done}, 0);
    chk("mid_nonce", nonce_latched, 0);
    reset = 0;
    exp_q.delete();
    arm(0);
    search(0, 7, 32'h55AA33CC);
    finish_frame(1, 32'h55AA33CC);
    // start during SEND is ignored, start in DONE re-arms with counter from 0
    arm(0);
    search(0, 4, 32'hDEADBEEF);
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    finish_frame(1, 32'hDEADBEEF);
    arm(0);
    chk("rearm2_busy", {31'h0, busy}, 1);
    chk("rearm2_done", {31'h0, done}, 0);
    search(0, 2, 32'h00C0FFEE);
    finish_frame(1, 32'h00C0FFEE);
    for (int r = 0; r < 10; r++) begin
      k = $urandom_range(0, 25);
      n = $urandom;
      bp_mode = $urandom_range(0, 2);
      arm(0);
      search(0, k, n);
      finish_frame(k < T, n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
